// File: rtl/spi_pkg.sv
// Shared SPI definitions: bit-order constants, mode encodings, frame phases
// and the bit-counter width helper.
package spi_pkg;

  localparam bit ORDER_LSB_FIRST = 1'b1;
  localparam bit ORDER_MSB_FIRST = 1'b0;

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'd0,
    SPI_MODE1 = 2'd1,
    SPI_MODE2 = 2'd2,
    SPI_MODE3 = 2'd3
  } spi_mode_e;

  typedef enum logic [1:0] {
    PH_LOAD  = 2'd0,
    PH_SHIFT = 2'd1,
    PH_DONE  = 2'd2
  } frame_phase_e;

  // Counter spans 0..data_w+1 (load, data_w shifts, completion).
  function automatic int unsigned cnt_width(input int unsigned data_w);
    return $clog2(data_w + 2);
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Direction-configurable SPI shift register: parallel load, serial shift,
// miso taken from the outgoing end.
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter bit          LSB_FIRST = ORDER_LSB_FIRST
) (
  input  logic              clk_int,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              shift_i,
  input  logic              mosi_i,
  output logic [DATA_W-1:0] sr_o,
  output logic              miso_o
);

  logic [DATA_W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = load_data_i;
    end else if (shift_i) begin
      sr_d = LSB_FIRST ? {mosi_i, sr_q[DATA_W-1:1]} : {sr_q[DATA_W-2:0], mosi_i};
    end
  end

  always_ff @(posedge clk_int or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sr_o   = sr_q;
  assign miso_o = LSB_FIRST ? sr_q[0] : sr_q[DATA_W-1];

endmodule

// File: rtl/spi_slave_param.sv
// Parameterised SPI slave on a pre-muxed shift clock: one load edge, DATA_W
// shift edges and one completion edge per frame, with TX/RX handshakes.
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter bit                LSB_FIRST = ORDER_LSB_FIRST,
  parameter logic [DATA_W-1:0] IDLE_WORD = '0
) (
  input  logic              clk_int,
  input  logic              reset,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic              err_clr,
  output logic              overrun,
  output logic              underrun,
  output logic              busy
);

  localparam int unsigned      CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W + 1);

  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  frame_phase_e      phase_c;
  logic              load_c, shift_c, done_c;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] load_word_c;

  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              overrun_q, overrun_d;
  logic              underrun_q, underrun_d;

  // Deselect aborts the frame immediately, independent of the shift clock.
  always_ff @(posedge clk_int or posedge reset or negedge ss) begin
    if (reset) begin
      bit_cnt_q <= '0;
    end else if (!ss) begin
      bit_cnt_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    phase_c   = PH_SHIFT;
    bit_cnt_d = bit_cnt_q + CNT_W'(1);
    if (bit_cnt_q == '0) begin
      phase_c = PH_LOAD;
    end else if (bit_cnt_q == CNT_LAST) begin
      phase_c   = PH_DONE;
      bit_cnt_d = '0;
    end
  end

  assign load_c      = ss && (phase_c == PH_LOAD);
  assign shift_c     = ss && (phase_c == PH_SHIFT);
  assign done_c      = ss && (phase_c == PH_DONE);
  assign load_word_c = tx_valid ? tx_data : IDLE_WORD;

  spi_shift_reg #(
    .DATA_W   (DATA_W),
    .LSB_FIRST(LSB_FIRST)
  ) u_shift_reg (
    .clk_int    (clk_int),
    .reset      (reset),
    .load_i     (load_c),
    .load_data_i(load_word_c),
    .shift_i    (shift_c),
    .mosi_i     (mosi),
    .sr_o       (sr),
    .miso_o     (miso)
  );

  // Completion outranks rx_ready; flag set events outrank err_clr.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    if (err_clr) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end
    if (rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (done_c) begin
      rx_data_d  = sr;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ready) begin
        overrun_d = 1'b1;
      end
    end
    if (load_c && !tx_valid) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_int or posedge reset) begin
    if (reset) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;
  assign underrun = underrun_q;
  assign tx_ready = ss && (bit_cnt_q == '0);
  assign busy     = ss && (bit_cnt_q != '0);

endmodule

// File: doc/spi_slave_param.md
SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, frame width in bits (legal 2..32).
REQ-002 SHALL have parameter LSB_FIRST, default 1, 1 = LSB shifted first, 0 = MSB first.
REQ-003 SHALL have parameter IDLE_WORD, default 0, word transmitted when no TX data is offered.
REQ-004 SHALL have port clk_int  input  1  shift clock, already mode-muxed from sclk/CPOL/CPHA upstream.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port ss  input  1  slave select, active-high.
REQ-007 SHALL have port mosi  input  1  serial data in.
REQ-008 SHALL have port miso  output  1  serial data out.
REQ-009 SHALL have ports tx_data  input  DATA_W, tx_valid  input  1, tx_ready  output  1: TX word handshake.
REQ-010 SHALL have ports rx_data  output  DATA_W, rx_valid  output  1, rx_ready  input  1: RX word handshake.
REQ-011 SHALL have ports err_clr  input  1, overrun  output  1, underrun  output  1, busy  output  1.

Function
REQ-012 SHALL keep bit counter bit_cnt, range 0..DATA_W+1, wrapping DATA_W+1 -> 0 so back-to-back frames run while ss high.
REQ-013 SHALL clear bit_cnt asynchronously while ss is low; a partial frame is discarded with no rx_valid and no flag change.
REQ-014 SHALL drive tx_ready = ss && (bit_cnt == 0), combinational.
REQ-015 SHALL, at an edge with bit_cnt == 0 and ss high, load shift register with tx_data if tx_valid, else with IDLE_WORD and set underrun.
REQ-016 SHALL, at edges with bit_cnt 1..DATA_W, shift mosi in: LSB_FIRST=1 -> {mosi, sr[DATA_W-1:1]}; LSB_FIRST=0 -> {sr[DATA_W-2:0], mosi}.
REQ-017 SHALL drive miso = sr[0] when LSB_FIRST=1, sr[DATA_W-1] when LSB_FIRST=0.
REQ-018 SHALL, at the edge with bit_cnt == DATA_W+1, write sr to rx_data and set rx_valid (1-edge latency after last data bit).
REQ-019 SHALL hold rx_valid and rx_data until an edge with rx_ready high, which clears rx_valid.
REQ-020 SHALL, if a new word completes while rx_valid is high and rx_ready low, overwrite rx_data, keep rx_valid high, set overrun.
REQ-021 SHALL give completion priority when completion and rx_ready coincide: rx_valid stays high with the new word, no overrun.
REQ-022 SHALL keep overrun and underrun sticky until err_clr is high at an edge; a set event in the same edge wins over err_clr.
REQ-023 SHALL drive busy = ss && (bit_cnt != 0).
REQ-024 SHALL size bit_cnt as clog2(DATA_W+2) bits with no arithmetic overflow at DATA_W=32.

Reset
REQ-025 SHALL on reset clear bit_cnt, sr, rx_data, rx_valid, overrun, underrun to 0, so miso = 0, tx_ready = ss, busy = 0.
REQ-026 SHALL treat reset mid-frame as frame abort; the first frame after reset starts with the load at bit_cnt == 0.

Structure
REQ-027 SHALL place the cnt-width function, the LSB_FIRST/MSB_FIRST constants and the mode encodings in shared package spi_pkg.
REQ-028 SHALL isolate the direction-configurable shift register in sub-module spi_shift_reg (parameters DATA_W, LSB_FIRST).
REQ-029 SHALL use only clk_int as clock; no logic is clocked on sclk directly.

Verification
REQ-030 SHALL cover DATA_W=8, LSB_FIRST=1: tx_data=8'hA5 valid, mosi streams 8'h3C -> miso LSB-first 1,0,1,0,0,1,0,1; rx_data=8'h3C, rx_valid set.
REQ-031 SHALL cover DATA_W=16, LSB_FIRST=0: tx 16'hBEEF, rx 16'h1234 -> miso MSB-first, rx_data=16'h1234.
REQ-032 SHALL cover two back-to-back frames with rx_ready low -> second word in rx_data, overrun=1; err_clr -> overrun=0.
REQ-033 SHALL cover tx_valid low at load, IDLE_WORD=8'hFF -> miso all 1s, underrun=1.
REQ-034 SHALL cover ss dropped after 4 bits, then a full frame -> first frame discarded, no rx_valid, second frame correct.
REQ-035 SHALL cover reset asserted mid-frame -> all outputs at reset values; next frame is received correctly.
